// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer.
// FSM state encoding and reset constants.
package timer_pkg;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } timer_state_t;

  localparam int RESET_COUNT = 0;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
// master drives control, slave is the timer.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load,
    output load_data,
    output start,
    output pause,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  load_data,
    input  start,
    input  pause,
    output count,
    output busy,
    output done
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause control,
// one-cycle done pulse and optional auto-reload.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0
) (
  input logic               clk,
  input logic               reset_n,
  countdown_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO =
    WIDTH'(RESET_COUNT);
  localparam logic [WIDTH-1:0] ONE  =
    WIDTH'(1);

  timer_state_t     state_q;
  timer_state_t     state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;

  // Next state: load > start > pause > decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (bus.load) begin
      count_d  = bus.load_data;
      reload_d = bus.load_data;
      state_d  = IDLE;
    end else if (state_q == IDLE) begin
      if (bus.start && count_q != ZERO) begin
        state_d = RUN;
      end
    end else if (bus.pause) begin
      count_d = count_q;
    end else if (count_q == ONE) begin
      done_d = 1'b1;
      if (AUTO_RELOAD != 0) begin
        count_d = reload_q;
      end else begin
        count_d = ZERO;
        state_d = IDLE;
      end
    end else if (count_q != ZERO) begin
      count_d = count_q - ONE;
    end
  end

  // State, count, reload and done registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one-shot and periodic
// instances against a behavioural model.
module tb_countdown_timer;

  localparam int W = 4;

  logic clk;
  logic reset_n;

  countdown_timer_if #(.WIDTH(W)) bus0 ();
  countdown_timer_if #(.WIDTH(W)) bus1 ();

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: index 0 one-shot, index 1 periodic.
  int m_cnt [2];
  int m_rl  [2];
  bit m_run [2];
  bit m_dn  [2];

  // Behavioural rules applied on every clock edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < 2; m++) begin
        m_cnt[m] <= 0;
        m_rl[m]  <= 0;
        m_run[m] <= 0;
        m_dn[m]  <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_dn[m] <= 0;
        if (bus0.load) begin
          m_cnt[m] <= int'(bus0.load_data);
          m_rl[m]  <= int'(bus0.load_data);
          m_run[m] <= 0;
        end else if (!m_run[m]) begin
          if (bus0.start && m_cnt[m] != 0)
            m_run[m] <= 1;
        end else if (bus0.pause) begin
        end else if (m_cnt[m] == 1) begin
          m_dn[m] <= 1;
          if (m == 1) begin
            m_cnt[m] <= m_rl[m];
          end else begin
            m_cnt[m] <= 0;
            m_run[m] <= 0;
          end
        end else if (m_cnt[m] > 1) begin
          m_cnt[m] <= m_cnt[m] - 1;
        end
      end
    end
  end

  // Compare both instances to the model every cycle.
  always @(negedge clk) begin
    chk("os_count", 32'(bus0.count), m_cnt[0]);
    chk("os_busy",  32'(bus0.busy),  32'(m_run[0]));
    chk("os_done",  32'(bus0.done),  32'(m_dn[0]));
    chk("pr_count", 32'(bus1.count), m_cnt[1]);
    chk("pr_busy",  32'(bus1.busy),  32'(m_run[1]));
    chk("pr_done",  32'(bus1.done),  32'(m_dn[1]));
  end

  task automatic drive(logic ld, int d, logic st,
                       logic ps);
    bus0.load      = ld;
    bus0.load_data = W'(d);
    bus0.start     = st;
    bus0.pause     = ps;
    bus1.load      = ld;
    bus1.load_data = W'(d);
    bus1.start     = st;
    bus1.pause     = ps;
  endtask

  task automatic step(logic ld, int d, logic st,
                      logic ps);
    drive(ld, d, st, ps);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0);
  endtask

  int exp_c;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    chk("rst_count", 32'(bus0.count), 0);
    chk("rst_busy",  32'(bus0.busy),  0);
    chk("rst_done",  32'(bus0.done),  0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot load 3.
    step(1, 3, 0, 0);
    chk("l3_count", 32'(bus0.count), 3);
    step(0, 0, 1, 0);
    chk("l3_start_c", 32'(bus0.count), 3);
    chk("l3_start_b", 32'(bus0.busy), 1);
    idle();
    chk("l3_c2", 32'(bus0.count), 2);
    idle();
    chk("l3_c1", 32'(bus0.count), 1);
    chk("l3_d1", 32'(bus0.done), 0);
    idle();
    chk("l3_c0", 32'(bus0.count), 0);
    chk("l3_done", 32'(bus0.done), 1);
    chk("l3_idle", 32'(bus0.busy), 0);
    chk("l3_pr_c", 32'(bus1.count), 3);
    chk("l3_pr_d", 32'(bus1.done), 1);
    chk("l3_pr_b", 32'(bus1.busy), 1);
    idle();
    chk("l3_drop", 32'(bus0.done), 0);
    chk("l3_pr_c2", 32'(bus1.count), 2);

    // Pause for 3 cycles at count 4.
    step(1, 5, 0, 0);
    step(0, 0, 1, 0);
    idle();
    chk("p_c4", 32'(bus0.count), 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("p_hold", 32'(bus0.count), 4);
      chk("p_busy", 32'(bus0.busy), 1);
    end
    for (int i = 3; i >= 0; i--) begin
      idle();
      chk("p_cnt", 32'(bus0.count), i);
      chk("p_done", 32'(bus0.done), (i == 0) ? 1 : 0);
    end

    // Load during RUN aborts; simultaneous start ignored.
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    idle();
    idle();
    idle();
    chk("a_c6", 32'(bus0.count), 6);
    step(1, 2, 1, 0);
    chk("a_c2", 32'(bus0.count), 2);
    chk("a_busy", 32'(bus0.busy), 0);
    chk("a_done", 32'(bus0.done), 0);
    step(0, 0, 1, 0);
    chk("a_run", 32'(bus0.busy), 1);
    idle();
    chk("a_c1", 32'(bus0.count), 1);
    idle();
    chk("a_c0", 32'(bus0.count), 0);
    chk("a_d", 32'(bus0.done), 1);

    // Start with zero count is ignored.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("z_busy", 32'(bus0.busy), 0);
    chk("z_count", 32'(bus0.count), 0);
    idle();
    chk("z_done", 32'(bus0.done), 0);

    // Periodic with period 4.
    step(1, 4, 0, 0);
    step(0, 0, 1, 0);
    chk("r4_c", 32'(bus1.count), 4);
    for (int i = 0; i < 8; i++) begin
      idle();
      exp_c = 3 - (i % 4);
      if (exp_c == 0) exp_c = 4;
      chk("r4_cnt", 32'(bus1.count), exp_c);
      chk("r4_done", 32'(bus1.done),
          (i % 4 == 3) ? 1 : 0);
    end

    // Periodic at max value 15.
    step(1, 15, 0, 0);
    step(0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      idle();
      chk("r15_cnt", 32'(bus1.count),
          (k == 15) ? 15 : 15 - k);
      chk("r15_done", 32'(bus1.done),
          (k == 15) ? 1 : 0);
    end

    // Async reset mid-count.
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    idle();
    idle();
    chk("ar_c7", 32'(bus0.count), 7);
    reset_n = 1'b0;
    #1;
    chk("ar_count", 32'(bus0.count), 0);
    chk("ar_busy",  32'(bus0.busy),  0);
    chk("ar_done",  32'(bus0.done),  0);
    chk("ar_pr_c",  32'(bus1.count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 1, 0);
    chk("ar_start", 32'(bus0.busy), 0);
    chk("ar_zero", 32'(bus0.count), 0);

    // Random phase checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) == 0),
           (($urandom_range(0, 3) == 0) ? 1
             : int'($urandom_range(0, 15))),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
